sobel_frame_scheduler: RTL and testbench

- Sequences a full grayscale frame through the 3x3 Sobel window controller (`sobel_control`).
- Reads pixels from a frame buffer with a 1-cycle synchronous read port and feeds them in vertical-strip order: 3 pixels per row, top to bottom, one strip per output column.
- Drives start/pixel-ready into the Sobel controller and tags each returned result with its (x,y) image coordinate.
- Sits between the grayscale frame buffer and the output writer.

---
 rtl/sobel_frame_scheduler.sv | 177 +++++++++++++++++
 tb/tb_sobel_frame_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_scheduler.sv
// Frame sequencer for the 3x3 Sobel window controller: vertical-strip pixel feed and (x,y) result tagging.
// Optional output thresholding is enabled with `define SOBEL_SCHED_THRESH_EN.
module sobel_frame_scheduler #(
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16,
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = $clog2(IMG_WIDTH*IMG_HEIGHT),
  parameter int GAP_CYCLES  = 2
) (
  input  logic                          clk_i,
  input  logic                          nreset_i,
  input  logic                          frame_start_i,
`ifdef SOBEL_SCHED_THRESH_EN
  input  logic [PIXEL_WIDTH-1:0]        thresh_i,
`endif
  output logic                          rd_en_o,
  output logic [ADDR_WIDTH-1:0]         rd_addr_o,
  input  logic [PIXEL_WIDTH-1:0]        rd_data_i,
  output logic                          start_sobel_o,
  output logic                          px_rdy_o,
  output logic [PIXEL_WIDTH-1:0]        px_o,
  input  logic [PIXEL_WIDTH-1:0]        sobel_px_i,
  input  logic                          sobel_rdy_i,
  output logic                          out_valid_o,
  output logic [PIXEL_WIDTH-1:0]        out_px_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_x_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_y_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int GW = $clog2(GAP_CYCLES);

  localparam logic [XW-1:0]         SX_LAST  = XW'(IMG_WIDTH - 3);
  localparam logic [YW-1:0]         ROW_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [YW-1:0]         RES_MAX  = YW'(IMG_HEIGHT - 2);
  localparam logic [GW-1:0]         GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] W_STEP   = ADDR_WIDTH'(IMG_WIDTH);

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, GAP, DONE} state_t;

  state_t                state;
  logic [XW-1:0]         sx;
  logic [YW-1:0]         row;
  logic [YW-1:0]         res_cnt;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] row_addr;
  logic [GW-1:0]         gap_cnt;
  logic                  result_ok;
  logic [PIXEL_WIDTH-1:0] result_px;

`ifdef SOBEL_SCHED_THRESH_EN
  logic [PIXEL_WIDTH-1:0] thresh_q;
  assign result_px = (sobel_px_i >= thresh_q) ? '1 : '0;
`else
  assign result_px = sobel_px_i;
`endif

  // Only the first IMG_HEIGHT-2 results of a live strip are tagged; anything else is dropped.
  assign result_ok = sobel_rdy_i && (state == FEED || state == DRAIN) && (res_cnt != RES_MAX);

  // Read data arrives one cycle after rd_en_o, aligned with the delayed strobe.
  assign px_o = px_rdy_o ? rd_data_i : '0;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state         <= IDLE;
      sx            <= '0;
      row           <= '0;
      res_cnt       <= '0;
      lane          <= '0;
      row_addr      <= '0;
      gap_cnt       <= '0;
      rd_en_o       <= 1'b0;
      rd_addr_o     <= '0;
      start_sobel_o <= 1'b0;
      px_rdy_o      <= 1'b0;
      out_valid_o   <= 1'b0;
      out_px_o      <= '0;
      out_x_o       <= '0;
      out_y_o       <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
`ifdef SOBEL_SCHED_THRESH_EN
      thresh_q      <= '0;
`endif
    end else begin
      px_rdy_o    <= rd_en_o;
      out_valid_o <= 1'b0;
      if (result_ok) begin
        out_valid_o <= 1'b1;
        out_px_o    <= result_px;
        out_x_o     <= sx + 1'b1;
        out_y_o     <= res_cnt + 1'b1;
        res_cnt     <= res_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_start_i) begin
            state         <= FEED;
            busy_o        <= 1'b1;
            start_sobel_o <= 1'b1;
            sx            <= '0;
            rd_en_o       <= 1'b1;
            rd_addr_o     <= '0;
            row_addr      <= '0;
            lane          <= '0;
            row           <= '0;
            res_cnt       <= '0;
`ifdef SOBEL_SCHED_THRESH_EN
            thresh_q      <= thresh_i;
`endif
          end
        end

        // row_addr tracks y*IMG_WIDTH+sx; lanes add 0..2 on top of it.
        FEED: begin
          if (lane == 2'd2) begin
            if (row == ROW_LAST) begin
              rd_en_o <= 1'b0;
              state   <= DRAIN;
            end else begin
              lane      <= '0;
              row       <= row + 1'b1;
              row_addr  <= row_addr + W_STEP;
              rd_addr_o <= row_addr + W_STEP;
            end
          end else begin
            lane      <= lane + 1'b1;
            rd_addr_o <= rd_addr_o + 1'b1;
          end
        end

        DRAIN: begin
          if (res_cnt == RES_MAX) begin
            state         <= GAP;
            start_sobel_o <= 1'b0;
            gap_cnt       <= '0;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (sx == SX_LAST) begin
              state  <= DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state         <= FEED;
              start_sobel_o <= 1'b1;
              sx            <= sx + 1'b1;
              rd_en_o       <= 1'b1;
              rd_addr_o     <= ADDR_WIDTH'(sx) + 1'b1;
              row_addr      <= ADDR_WIDTH'(sx) + 1'b1;
              lane          <= '0;
              row           <= '0;
              res_cnt       <= '0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Randomized self-checking bench for sobel_frame_scheduler (4x4 frame) with a Sobel-controller stub
// and a strip-order reference model.
module tb_sobel_frame_scheduler;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int PW  = 8;
  localparam int AW  = $clog2(W*H);
  localparam int GAP = 2;
  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          frame_start = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data = '0;
  logic          start_sobel;
  logic          px_rdy;
  logic [PW-1:0] px;
  logic [PW-1:0] sobel_px = '0;
  logic          sobel_rdy = 1'b0;
  logic          out_valid;
  logic [PW-1:0] out_px;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          busy;
  logic          done;
`ifdef SOBEL_SCHED_THRESH_EN
  logic [PW-1:0] thresh_in = '0;
  logic [PW-1:0] thr_frame = '0;
`endif

  always #5 clk = ~clk;

  sobel_frame_scheduler #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .GAP_CYCLES(GAP)
  ) dut (
    .clk_i(clk), .nreset_i(nreset), .frame_start_i(frame_start),
`ifdef SOBEL_SCHED_THRESH_EN
    .thresh_i(thresh_in),
`endif
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .start_sobel_o(start_sobel), .px_rdy_o(px_rdy), .px_o(px),
    .sobel_px_i(sobel_px), .sobel_rdy_i(sobel_rdy),
    .out_valid_o(out_valid), .out_px_o(out_px), .out_x_o(out_x), .out_y_o(out_y),
    .busy_o(busy), .done_o(done)
  );

  // Frame buffer with a 1-cycle synchronous read port.
  logic [PW-1:0] mem [W*H];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct {
    int            due;
    logic [PW-1:0] v;
    bit            keep;
    int            x;
    int            y;
  } res_t;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc = 0;
  res_t pend[$];
  res_t expq[$];
  int   exp_addr[$];
  int   rd_idx, prev_addr, strip, low_run, pix_in_strip, n_results, dir_idx;
  bit   prev_rd_en, prev_start, extra_mode, done_seen;
  logic [PW-1:0] dir_vals [3] = '{8'd127, 8'd128, 8'd255};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({rd_en, rd_addr, start_sobel, px_rdy, px, out_valid, out_px, out_x, out_y, busy, done});
  endfunction

  function automatic logic [PW-1:0] exp_px(input logic [PW-1:0] v);
`ifdef SOBEL_SCHED_THRESH_EN
    return (v >= thr_frame) ? '1 : '0;
`else
    return v;
`endif
  endfunction

  function automatic logic [PW-1:0] next_val();
    logic [PW-1:0] v;
    if (dir_idx < 3) v = dir_vals[dir_idx];
    else             v = PW'($urandom_range(0, 255));
    dir_idx++;
    return v;
  endfunction

  task automatic model_reset();
    pend.delete();
    expq.delete();
    prev_rd_en   = 1'b0;
    prev_start   = 1'b0;
    strip        = -1;
    low_run      = 0;
    pix_in_strip = 0;
  endtask

  task automatic frame_init(input bit extra);
    model_reset();
    for (int i = 0; i < W*H; i++) mem[i] = PW'($urandom);
    exp_addr.delete();
    for (int s = 0; s <= W-3; s++)
      for (int y = 0; y < H; y++)
        for (int k = 0; k < 3; k++) exp_addr.push_back(y*W + s + k);
    rd_idx     = 0;
    n_results  = 0;
    extra_mode = extra;
    done_seen  = 1'b0;
  endtask

  // One clock: sample at the falling edge, check, then drive inputs for the coming rising edge.
  task automatic step();
    res_t r, e;
    bit   exp_valid;
    @(negedge clk);
    cyc++;
    if (rd_en) begin
      chk("rd_addr", 32'(rd_addr), (rd_idx < exp_addr.size()) ? 32'(exp_addr[rd_idx]) : 32'hFFFF);
      rd_idx++;
    end
    chk("px_rdy", 32'(px_rdy), 32'(prev_rd_en));
    if (px_rdy) chk("px", 32'(px), 32'(mem[prev_addr]));
    prev_rd_en = rd_en;
    prev_addr  = int'(rd_addr);

    if (start_sobel && !prev_start) begin
      if (strip >= 0) chk("gap_len", 32'(low_run), 32'(GAP));
      strip++;
      pix_in_strip = 0;
      low_run = 0;
    end
    if (!start_sobel) low_run++;
    prev_start = start_sobel;

    // Sobel stub: a window completes on every full row once three rows are in; result 2 cycles later.
    if (start_sobel && px_rdy) begin
      pix_in_strip++;
      if (pix_in_strip >= 9 && pix_in_strip % 3 == 0) begin
        r.due = cyc + 2; r.v = next_val(); r.keep = 1'b1;
        r.x = strip + 1; r.y = pix_in_strip/3 - 2;
        pend.push_back(r);
        if (extra_mode && r.y == H-2) begin
          r.due = cyc + 3; r.v = PW'($urandom); r.keep = 1'b0;
          pend.push_back(r);
        end
      end
    end

    exp_valid = (expq.size() > 0) && (expq[0].due == cyc);
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      e = expq.pop_front();
      if (out_valid) begin
        chk("out_px", 32'(out_px), 32'(exp_px(e.v)));
        chk("out_x", 32'(out_x), 32'(e.x));
        chk("out_y", 32'(out_y), 32'(e.y));
        n_results++;
      end
    end

    if (done) begin
      done_seen = 1'b1;
      chk("done_busy", 32'(busy), 32'd0);
      chk("frame_reads", 32'(rd_idx), 32'(3*H*(W-2)));
      chk("frame_results", 32'(n_results), 32'((W-2)*(H-2)));
    end

    sobel_rdy = 1'b0;
    sobel_px  = PW'($urandom);
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      sobel_rdy = 1'b1;
      sobel_px  = r.v;
      if (r.keep) begin
        r.due = cyc + 1;
        expq.push_back(r);
      end
    end else if (extra_mode && busy && !start_sobel) begin
      sobel_rdy = 1'b1;
    end
  endtask

  task automatic start_pulse();
    frame_start = 1'b1;
`ifdef SOBEL_SCHED_THRESH_EN
    thresh_in = 8'd128;
    thr_frame = 8'd128;
`endif
    step();
    frame_start = 1'b0;
`ifdef SOBEL_SCHED_THRESH_EN
    thresh_in = 8'd200;
`endif
  endtask

  task automatic run_frame(input bit extra);
    int t;
    frame_init(extra);
    start_pulse();
    t = 0;
    while (!done_seen && t < 500) begin
      step();
      t++;
    end
    chk("frame_done", 32'(done_seen), 32'd1);
    step();
    chk("done_pulse", 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int t;
    dir_idx = 0;
    model_reset();
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (10) begin
      step();
      chk("idle_outs", all_outs(), 32'd0);
    end

    run_frame(1'b0);
    run_frame(1'b1);

    // Start pulse mid-FEED is ignored, then an asynchronous reset lands in DRAIN.
    frame_init(1'b0);
    start_pulse();
    repeat (3) step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("busy_feed", 32'(busy), 32'd1);
    t = 0;
    while (rd_idx < 3*H && t < 200) begin
      step();
      t++;
    end
    chk("abort_reads", 32'(rd_idx), 32'(3*H));
    step();
    chk("drain_state", 32'({start_sobel, rd_en, busy}), 32'b101);
    nreset = 1'b0;
    model_reset();
    repeat (2) begin
      step();
      chk("reset_outs", all_outs(), 32'd0);
    end
    nreset = 1'b1;
    repeat (5) begin
      step();
      chk("post_reset_outs", all_outs(), 32'd0);
    end

    run_frame(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
